// File: rtl/write_back_pkg.sv
// Shared types and constants for the write-back stage: register file shape,
// Flags register location and the write-back FSM state encoding.
package write_back_pkg;

  localparam int REG_COUNT   = 32;
  localparam int REG_INDEX_W = 5;
  localparam int REG_WIDTH   = 32;
  localparam int FLAGS_INDEX = 30;
  localparam int FLAGS_LSB   = 27;
  localparam int FLAGS_W     = 4;

  typedef logic [REG_INDEX_W-1:0] regind_t;
  typedef logic [REG_WIDTH-1:0]   regval_t;
  typedef regval_t [REG_COUNT-1:0] regfile_t;

  // Bit order inside the Flags field, MSB first.
  typedef struct packed {
    logic carry;
    logic negative;
    logic overflow;
    logic zero;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UPPER = 2'd1,
    STORE = 2'd2
  } wb_state_t;

  function automatic regval_t merge_flags(regval_t value, flags_t flags);
    regval_t merged;
    merged = value;
    merged[FLAGS_LSB +: FLAGS_W] = flags;
    return merged;
  endfunction

endpackage

// File: rtl/write_back_regfile.sv
// Architectural register file: one general write port, a dedicated Flags-field
// update, flat read-out of every register, and r0 hard-wired to zero.
module write_back_regfile
  import write_back_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     we,
  input  regind_t  waddr,
  input  regval_t  wdata,
  input  logic     flags_we,
  input  flags_t   flags,
  output regfile_t registers
);

  regval_t regs_q [1:REG_COUNT-1];

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign registers[gi] = '0;
      end else begin : g_live
        regval_t reg_d;

        // The general write is applied last so a full write to Flags wins.
        always_comb begin
          reg_d = regs_q[gi];
          if (flags_we && (gi == FLAGS_INDEX)) begin
            reg_d = merge_flags(reg_d, flags);
          end
          if (we && (waddr == regind_t'(gi))) begin
            reg_d = wdata;
          end
        end

        always_ff @(posedge clock) begin
          if (reset) begin
            regs_q[gi] <= '0;
          end else begin
            regs_q[gi] <= reg_d;
          end
        end

        assign registers[gi] = regs_q[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/write_back.sv
// Final pipeline stage: commits retired instructions to the register file,
// issues stores over a ready/valid port and drives same-cycle forwarding.
module write_back
  import write_back_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     in_valid,
  output logic     in_hold,
  input  regval_t  in_pc,
  input  regind_t  in_target_register,
  input  regind_t  in_address_register,
  input  logic     in_is_writing_memory,
  input  flags_t   in_flags,
  input  regval_t  in_target_value,
  input  logic     in_has_upper_value,
  input  regval_t  in_upper_value,
  input  regval_t  in_adjustment_value,
  input  logic     in_has_flushed,
  output regfile_t registers,
  output logic     mem_write,
  output regval_t  mem_address,
  output regval_t  mem_data,
  input  logic     mem_ready,
  output logic     fb_valid,
  output regind_t  fb_index,
  output regval_t  fb_value,
  output regval_t  retired_pc
);

  wb_state_t state_q, state_d;
  logic      mem_write_q, mem_write_d;
  regval_t   mem_address_q, mem_address_d;
  regval_t   mem_data_q, mem_data_d;
  regval_t   retired_pc_q, retired_pc_d;

  logic    wr_en;
  regind_t wr_index;
  regval_t wr_value;
  logic    wr_commit;
  logic    flags_en;
  regval_t store_base;

  // Base register as it will read after this cycle's commit, so a store may
  // use the very register its own instruction just wrote.
  always_comb begin
    store_base = registers[in_address_register];
    if (in_address_register == regind_t'(FLAGS_INDEX)) begin
      store_base = merge_flags(store_base, in_flags);
    end
    if (in_address_register == in_target_register) begin
      store_base = in_target_value;
    end
    if (in_address_register == '0) begin
      store_base = '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    retired_pc_d  = retired_pc_q;
    wr_en         = 1'b0;
    wr_index      = in_target_register;
    wr_value      = in_target_value;
    flags_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && !in_has_flushed) begin
          wr_en        = 1'b1;
          flags_en     = 1'b1;
          retired_pc_d = in_pc;
          if (in_is_writing_memory) begin
            state_d       = STORE;
            mem_write_d   = 1'b1;
            mem_address_d = store_base + in_adjustment_value;
            mem_data_d    = in_target_value;
          end else if (in_has_upper_value) begin
            state_d = UPPER;
          end
        end
      end
      UPPER: begin
        wr_en    = 1'b1;
        wr_index = in_target_register + regind_t'(1);
        wr_value = in_upper_value;
        state_d  = IDLE;
      end
      STORE: begin
        if (mem_ready) begin
          mem_write_d = 1'b0;
          state_d     = in_has_upper_value ? UPPER : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wr_commit = wr_en && (wr_index != '0) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      retired_pc_q  <= '0;
    end else begin
      state_q       <= state_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      retired_pc_q  <= retired_pc_d;
    end
  end

  write_back_regfile u_regfile (
    .clock     (clock),
    .reset     (reset),
    .we        (wr_commit),
    .waddr     (wr_index),
    .wdata     (wr_value),
    .flags_we  (flags_en && !reset),
    .flags     (in_flags),
    .registers (registers)
  );

  assign in_hold     = !reset && (state_d != IDLE);
  assign fb_valid    = wr_commit;
  assign fb_index    = wr_commit ? wr_index : '0;
  assign fb_value    = wr_commit ? wr_value : '0;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign retired_pc  = retired_pc_q;

endmodule

// File: doc/write_back.md
# write_back

Final pipeline stage. It accepts retired instructions from the execute stage, commits results to the architectural register file, and performs data-memory writes through a ready/valid handshake. It updates the Flags register and drives the forwarding feedback that execute and read use to see in-flight results. It owns the register file and exports it as a whole to the earlier stages.

## Interface
- `REG_COUNT`, 32: number of architectural registers; index width is 5.
- `FLAGS_INDEX`, 30: register index of Flags.
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: execute output holds a retired instruction.
- `in_hold` out 1: back-pressure to execute; execute keeps its outputs stable while this is high.
- `in_pc` in 32: PC of the instruction; captured to `retired_pc`.
- `in_target_register` in 5: destination register index.
- `in_address_register` in 5: base register for a memory write.
- `in_is_writing_memory` in 1: instruction stores to memory.
- `in_flags` in 4: {carry, negative, overflow, zero}.
- `in_target_value` in 32: primary result; also the store data.
- `in_has_upper_value` in 1: a second result exists.
- `in_upper_value` in 32: second result.
- `in_adjustment_value` in 32: store address offset.
- `in_has_flushed` in 1: instruction is annulled; nothing is committed.
- `registers` out 32×32: register-file contents (`regfile_t`).
- `mem_write` out 1: store request valid.
- `mem_address` out 32: store address.
- `mem_data` out 32: store data.
- `mem_ready` in 1: memory accepts the store this cycle.
- `fb_valid` out 1: forwarding is active this cycle.
- `fb_index` out 5: index being written.
- `fb_value` out 32: value being written.
- `retired_pc` out 32: PC of the last committed instruction.

## Operation
- FSM states: IDLE, UPPER, STORE.
- **IDLE**, with `in_valid` and `!in_has_flushed`:
  - Write `in_target_value` to `in_target_register`.
  - Write `in_flags` into Flags bits [30:27].
  - Update `retired_pc`.
  - If `in_is_writing_memory`, go to STORE. Else if `in_has_upper_value`, go to UPPER. Else stay in IDLE.
- **IDLE**, with `in_has_flushed`: the instruction is consumed in one cycle. No register write, no flags write, no store, no `retired_pc` update.
- **Target is Flags**: the target write wins over the flags-field update.
- **Register 0** reads as zero. Writes to index 0 are dropped, both primary and upper.
- **UPPER**: write `in_upper_value` to `(in_target_register+1) mod 32`, then go to IDLE.
- **STORE**:
  - `mem_address = registers[in_address_register] + in_adjustment_value`, modulo 2^32, using the register value after this instruction's IDLE-cycle commit.
  - `mem_data = in_target_value`; `mem_write = 1`.
  - Stay in STORE until `mem_ready`.
  - On acceptance, go to UPPER if `in_has_upper_value` (swap/compare-exchange), else go to IDLE.
- **`in_hold`**: high whenever the next state is not IDLE, so the input is held stable for multi-cycle instructions.
- **Feedback**: combinational with the register write of the current cycle. `fb_valid`, `fb_index` and `fb_value` reflect whichever write (primary or upper) happens this cycle. `fb_valid` is 0 when no write occurs.

## Timing
- Simple instruction: committed at the edge that ends its `in_valid` cycle. Visible on `registers` the next cycle, and on `fb_*` in the same cycle.
- Upper value: 2 cycles; `in_hold` is high in cycle 1.
- Store: at least 2 cycles. `mem_write` rises the cycle after acceptance and stays high with stable address and data until the `mem_ready` cycle. It drops the next cycle unless UPPER follows.
- `mem_ready` while `mem_write` is low is ignored.
- Reset values:
  - state IDLE
  - all registers 0
  - `in_hold` 0, `mem_write` 0, `mem_address` 0, `mem_data` 0
  - `fb_valid` 0, `fb_index` 0, `fb_value` 0
  - `retired_pc` 0
- Reset mid-STORE: the store is abandoned and `mem_write` is 0 the next cycle.

## Structure
- Shared package: `regind_t`, `regval_t`, `regfile_t`, `FLAGS_INDEX`, `FLAGS_LSB`=27, and the flag bit order.
- Sub-module `regfile`: single write port, flat read-out of all registers, R0 tied to zero.

## Test plan
- Reset, then ADD result 0x0000_0005 to r3 with flags 4'b0001 → r3=5, Flags[30:27]=0001, `fb_valid`=1 with `fb_index`=3 in the same cycle, `in_hold` stays 0.
- MUL with upper=0x1, target r31, value 0xFFFF_FFFE → r31=0xFFFF_FFFE; next cycle r0 stays 0 (wrap, dropped write); `in_hold` high for 1 cycle.
- Store with r4=0x1000, offset 0x10, data 0xDEAD_BEEF, `mem_ready` delayed 3 cycles → `mem_write` high exactly 4 cycles at 0x1010 with stable data, `in_hold` high throughout.
- Flushed instruction targeting r7 with store set → no register write, `mem_write` never rises, `retired_pc` unchanged.
- Target = Flags, value 0x1234_5678 → Flags = 0x1234_5678 (flags field not overwritten).
- Reset asserted during STORE wait → `mem_write`=0, all registers 0, and a new instruction is accepted normally afterwards.
